// File: rtl/k_and_s_pkg.sv
// K&S processor shared encodings: decoded instructions, control FSM states, ALU ops.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package k_and_s_pkg;

    typedef enum logic [4:0] {
        I_NOP    = 5'd0,
        I_LOAD   = 5'd1,
        I_STORE  = 5'd2,
        I_MOVE   = 5'd3,
        I_ADD    = 5'd4,
        I_SUB    = 5'd5,
        I_AND    = 5'd6,
        I_OR     = 5'd7,
        I_BRANCH = 5'd8,
        I_BZERO  = 5'd9,
        I_BNZERO = 5'd10,
        I_BNEG   = 5'd11,
        I_BNNEG  = 5'd12,
        I_BOV    = 5'd13,
        I_BNOV   = 5'd14,
        I_BSOV   = 5'd15,
        I_BNSOV  = 5'd16,
        I_HALT   = 5'd17
    } decoded_instruction_type;

    // Wait states are always present so state encodings do not move with the build option.
    typedef enum logic [3:0] {
        S_FETCH      = 4'd0,
        S_FETCH_WAIT = 4'd1,
        S_DECODE     = 4'd2,
        S_LOAD_WAIT  = 4'd3,
        S_ALU        = 4'd4,
        S_LOAD       = 4'd5,
        S_STORE      = 4'd6,
        S_MOVE       = 4'd7,
        S_BRANCH     = 4'd8,
        S_NEXT       = 4'd9,
        S_HALT       = 4'd10
    } ctrl_state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    // Map an ALU-class instruction onto its ALU operation code.
    function automatic logic [1:0] alu_op_of(input decoded_instruction_type instr);
        case (instr)
            I_SUB:   alu_op_of = OP_SUB;
            I_AND:   alu_op_of = OP_AND;
            I_OR:    alu_op_of = OP_OR;
            default: alu_op_of = OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_branch_eval.sv
// Branch condition evaluator: decides whether the decoded branch is taken from the flags.
// Latency: purely combinational, 0 cycles.
// Backpressure: none.
module branch_eval
    import k_and_s_pkg::*;
(
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    taken
);

    // Non-branch instructions report not-taken so the caller can use taken unguarded.
    always_comb begin
        taken = 1'b0;
        case (decoded_instruction)
            I_BRANCH: taken = 1'b1;
            I_BZERO:  taken = zero_op;
            I_BNZERO: taken = !zero_op;
            I_BNEG:   taken = neg_op;
            I_BNNEG:  taken = !neg_op;
            I_BOV:    taken = unsigned_overflow;
            I_BNOV:   taken = !unsigned_overflow;
            I_BSOV:   taken = signed_overflow;
            I_BNSOV:  taken = !signed_overflow;
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// K&S sequencing FSM: fetch/decode/execute, drives every data path enable and select.
// Latency: 3 cycles per instruction; with KS_CTRL_MEM_WAIT_EN 4 (LOAD 5) for sync-read RAM.
// Backpressure: none; HALT holds until rst, rst forces all outputs low.
module control_unit
    import k_and_s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt
);

    ctrl_state_t state;
    ctrl_state_t state_nxt;
    logic        taken;

    branch_eval u_branch_eval (
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .taken               (taken)
    );

    // Next-state selection: fetch, decode by instruction class, execute, back to fetch.
    always_comb begin
        state_nxt = state;
        case (state)
`ifdef KS_CTRL_MEM_WAIT_EN
            S_FETCH:      state_nxt = S_FETCH_WAIT;
`else
            S_FETCH:      state_nxt = S_DECODE;
`endif
            S_FETCH_WAIT: state_nxt = S_DECODE;
            S_DECODE: begin
                case (decoded_instruction)
                    I_ADD, I_SUB, I_AND, I_OR: state_nxt = S_ALU;
`ifdef KS_CTRL_MEM_WAIT_EN
                    I_LOAD:                    state_nxt = S_LOAD_WAIT;
`else
                    I_LOAD:                    state_nxt = S_LOAD;
`endif
                    I_STORE:                   state_nxt = S_STORE;
                    I_MOVE:                    state_nxt = S_MOVE;
                    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG,
                    I_BOV, I_BNOV, I_BSOV, I_BNSOV:
                                               state_nxt = S_BRANCH;
                    I_HALT:                    state_nxt = S_HALT;
                    default:                   state_nxt = S_NEXT;
                endcase
            end
            S_LOAD_WAIT:  state_nxt = S_LOAD;
            S_HALT:       state_nxt = S_HALT;
            default:      state_nxt = S_FETCH;
        endcase
    end

    // State register with synchronous reset back to fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Moore output decode; held low during rst so an abandoned instruction writes nothing.
    always_comb begin
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        operation        = OP_ADD;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halt             = 1'b0;
        if (!rst) begin
            case (state)
`ifdef KS_CTRL_MEM_WAIT_EN
                S_FETCH:      ir_enable = 1'b0;
`else
                S_FETCH:      ir_enable = 1'b1;
`endif
                S_FETCH_WAIT: ir_enable = 1'b1;
                S_LOAD_WAIT:  addr_sel  = 1'b1;
                S_ALU: begin
                    operation        = alu_op_of(decoded_instruction);
                    write_reg_enable = 1'b1;
                    flags_reg_enable = 1'b1;
                    pc_enable        = 1'b1;
                end
                S_LOAD: begin
                    addr_sel         = 1'b1;
                    c_sel            = 1'b1;
                    write_reg_enable = 1'b1;
                    pc_enable        = 1'b1;
                end
                S_STORE: begin
                    addr_sel         = 1'b1;
                    ram_write_enable = 1'b1;
                    pc_enable        = 1'b1;
                end
                S_MOVE: begin
                    operation        = OP_OR;
                    write_reg_enable = 1'b1;
                    pc_enable        = 1'b1;
                end
                S_BRANCH: begin
                    pc_enable = 1'b1;
                    branch    = taken;
                end
                S_NEXT:       pc_enable = 1'b1;
                S_HALT:       halt      = 1'b1;
                default:      halt      = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit against a per-instruction cycle model.
// Latency: follows KS_CTRL_MEM_WAIT_EN when the same define is given to the bench.
// Backpressure: n/a.
module tb_control_unit;
    import k_and_s_pkg::*;

    typedef struct packed {
        logic       halt;
        logic       branch;
        logic       pc_enable;
        logic       ir_enable;
        logic       addr_sel;
        logic       c_sel;
        logic [1:0] operation;
        logic       write_reg_enable;
        logic       flags_reg_enable;
        logic       ram_write_enable;
    } ctl_t;

    logic                    clk = 1'b0;
    logic                    rst;
    decoded_instruction_type decoded_instruction;
    logic                    zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic                    branch, pc_enable, ir_enable, addr_sel, c_sel;
    logic [1:0]              operation;
    logic                    write_reg_enable, flags_reg_enable, ram_write_enable, halt;
    ctl_t                    obs;

    int checks   = 0;
    int failures = 0;

    control_unit dut (
        .clk                 (clk),
        .rst                 (rst),
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .operation           (operation),
        .write_reg_enable    (write_reg_enable),
        .flags_reg_enable    (flags_reg_enable),
        .ram_write_enable    (ram_write_enable),
        .halt                (halt)
    );

    always #5 clk = ~clk;

    assign obs = '{halt, branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
                   write_reg_enable, flags_reg_enable, ram_write_enable};

    // Expected outputs of the execute cycle; f = {zero, neg, unsigned ovf, signed ovf}.
    function automatic ctl_t exp_exec(input decoded_instruction_type i, input logic [3:0] f);
        ctl_t c;
        int   idx;
        logic sel;
        c = '0;
        case (i)
            I_ADD, I_SUB, I_AND, I_OR: begin
                c.write_reg_enable = 1'b1;
                c.flags_reg_enable = 1'b1;
                c.pc_enable        = 1'b1;
                c.operation = (i == I_ADD) ? 2'b00 : (i == I_AND) ? 2'b01 :
                              (i == I_OR)  ? 2'b10 : 2'b11;
            end
            I_LOAD: begin
                c.addr_sel = 1'b1; c.c_sel = 1'b1; c.write_reg_enable = 1'b1; c.pc_enable = 1'b1;
            end
            I_STORE: begin
                c.addr_sel = 1'b1; c.ram_write_enable = 1'b1; c.pc_enable = 1'b1;
            end
            I_MOVE: begin
                c.operation = 2'b10; c.write_reg_enable = 1'b1; c.pc_enable = 1'b1;
            end
            I_BRANCH: begin
                c.pc_enable = 1'b1; c.branch = 1'b1;
            end
            I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_BSOV, I_BNSOV: begin
                // Conditional branches come in (flag, !flag) pairs ordered zero, neg, uov, sov.
                idx = int'(i) - int'(I_BZERO);
                sel = f[3 - idx / 2];
                c.pc_enable = 1'b1;
                c.branch    = (idx % 2 == 0) ? sel : !sel;
            end
            I_HALT: c.halt = 1'b1;
            default: c.pc_enable = 1'b1;
        endcase
        return c;
    endfunction

    // Sample at the falling edge, then advance to just after the next rising edge.
    task automatic check(input ctl_t exp, input string tag);
        @(negedge clk);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    // One full instruction from fetch through execute; the IR changes after the ir_enable cycle.
    task automatic run_instr(input decoded_instruction_type i, input logic [3:0] f, input string tag);
        ctl_t e;
        {zero_op, neg_op, unsigned_overflow, signed_overflow} = f;
        e = '0;
`ifdef KS_CTRL_MEM_WAIT_EN
        check(e, {tag, "_fetch"});
`endif
        e.ir_enable = 1'b1;
        check(e, {tag, "_ir"});
        decoded_instruction = i;
        check('0, {tag, "_decode"});
`ifdef KS_CTRL_MEM_WAIT_EN
        if (i == I_LOAD) begin
            e = '0;
            e.addr_sel = 1'b1;
            check(e, {tag, "_loadwait"});
        end
`endif
        check(exp_exec(i, f), {tag, "_exec"});
    endtask

    function automatic decoded_instruction_type rand_instr();
        if ($urandom_range(0, 9) == 0)
            return decoded_instruction_type'(5'($urandom_range(18, 31)));
        return decoded_instruction_type'(5'($urandom_range(0, 16)));
    endfunction

    initial begin
        ctl_t e;
        rst = 1'b1;
        decoded_instruction = I_NOP;
        {zero_op, neg_op, unsigned_overflow, signed_overflow} = 4'b0000;
        @(posedge clk);
        #1;
        check('0, "reset0");
        check('0, "reset1");
        rst = 1'b0;

        run_instr(I_NOP,    4'b0000, "nop");
        run_instr(I_ADD,    4'b0000, "add");
        run_instr(I_BZERO,  4'b1000, "bzero_taken");
        run_instr(I_BNZERO, 4'b1000, "bnzero_not");
        run_instr(I_LOAD,   4'b0101, "load");
        run_instr(I_STORE,  4'b1111, "store");
        run_instr(I_MOVE,   4'b0110, "move");
        run_instr(I_SUB,    4'b0000, "sub");
        run_instr(I_AND,    4'b0000, "and");
        run_instr(I_OR,     4'b0000, "or");
        run_instr(I_BRANCH, 4'b0000, "branch");
        run_instr(I_BSOV,   4'b0001, "bsov_taken");
        run_instr(I_BNSOV,  4'b0001, "bnsov_not");
        run_instr(decoded_instruction_type'(5'd25), 4'b0000, "unlisted");

        for (int n = 0; n < 150; n++) begin
            run_instr(rand_instr(), 4'($urandom_range(0, 15)), "rand");
        end

        // HALT holds with every strobe low regardless of flags.
        run_instr(I_HALT, 4'b1010, "halt");
        e = '0;
        e.halt = 1'b1;
        for (int n = 0; n < 20; n++) begin
            {zero_op, neg_op, unsigned_overflow, signed_overflow} = 4'($urandom_range(0, 15));
            check(e, "halt_hold");
        end

        // One-cycle reset leaves HALT and refetches.
        rst = 1'b1;
        check('0, "halt_rst");
        rst = 1'b0;
        run_instr(I_NOP, 4'b0000, "after_halt");

        // Reset in the middle of an instruction suppresses its write strobe.
        e = '0;
`ifdef KS_CTRL_MEM_WAIT_EN
        check(e, "mid_fetch");
        e.ir_enable = 1'b1;
        check(e, "mid_ir");
        decoded_instruction = I_LOAD;
        check('0, "mid_decode");
        rst = 1'b1;
        check('0, "mid_rst_loadwait");
`else
        e.ir_enable = 1'b1;
        check(e, "mid_ir");
        decoded_instruction = I_STORE;
        check('0, "mid_decode");
        rst = 1'b1;
        check('0, "mid_rst_store");
`endif
        rst = 1'b0;
        run_instr(I_LOAD, 4'b0000, "restart_load");
        run_instr(rand_instr(), 4'($urandom_range(0, 15)), "final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
